// File: rtl/regbank_arb_pkg.sv
// Shared types and defaults for the register-bank write arbiter.
// Holds the FSM state encoding and a one-hot helper used for grant vectors.
package regbank_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 8;
    localparam int DEF_AW   = 3;
    localparam int MAX_NREQ = 8;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regbank_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit at or above ptr, wrapping modulo N.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Reusable by any round-robin arbiter in the datapath.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] win
);

    // Scan from the farthest offset down so the nearest candidate is written last.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                valid = 1'b1;
                win   = PW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter owning a DEPTH x DW register bank with one shared write port.
// Latency: req sampled at edge t, gnt/busy high t..t+1, bank written at edge t+1; one write per 2 cycles.
// Backpressure: requesters hold req/addr/data until gnt; optional lock via REGBANK_ARB_LOCK_EN.
module regbank_arbiter
    import regbank_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
`ifdef REGBANK_ARB_LOCK_EN
    input  logic [NREQ-1:0]    lock,
`endif
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    input  logic [AW-1:0]      rd_addr,
    output logic [DW-1:0]      rd_data
);

    localparam int DEPTH = 1 << AW;
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [DW-1:0]     bank_q [DEPTH];
    logic [DW-1:0]     bank_d [DEPTH];
    logic              pick_vld;
    logic [PW-1:0]     pick_win;
    logic [PW-1:0]     sel_win;
    logic [PW-1:0]     ptr_nxt;
`ifdef REGBANK_ARB_LOCK_EN
    logic              hold_q, hold_d;
    logic              last_vld_q, last_vld_d;
`endif

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_vld),
        .win   (pick_win)
    );

    assign ptr_nxt = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        bank_d  = bank_q;
        sel_win = pick_win;
`ifdef REGBANK_ARB_LOCK_EN
        hold_d     = hold_q;
        last_vld_d = last_vld_q;
        // A locked previous winner re-wins without rotating the pointer.
        if (last_vld_q && req[win_q] && lock[win_q]) begin
            sel_win = win_q;
        end
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = NREQ'(onehot(3'(sel_win)));
                    addr_d  = wr_addr[int'(sel_win)*AW +: AW];
                    data_d  = wr_data[int'(sel_win)*DW +: DW];
                    win_d   = sel_win;
                    state_d = GRANT;
`ifdef REGBANK_ARB_LOCK_EN
                    hold_d  = last_vld_q && req[win_q] && lock[win_q];
`endif
                end
            end
            GRANT: begin
                bank_d[addr_q] = data_q;
                gnt_d          = '0;
                state_d        = IDLE;
`ifdef REGBANK_ARB_LOCK_EN
                last_vld_d     = 1'b1;
                if (!hold_q) begin
                    ptr_d = ptr_nxt;
                end
`else
                ptr_d          = ptr_nxt;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
`ifdef REGBANK_ARB_LOCK_EN
            hold_q     <= 1'b0;
            last_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            bank_q  <= bank_d;
`ifdef REGBANK_ARB_LOCK_EN
            hold_q     <= hold_d;
            last_vld_q <= last_vld_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == GRANT);
    assign rd_data = bank_q[rd_addr];

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: vector table for single writes plus hand sequences
// for rotation, wrap, reset mid-grant, continuous contention and (when enabled) lock bursts.
module tb_regbank_arbiter;

    logic        clk = 1'b0;
    logic        rstb;
    logic [3:0]  req;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  gnt;
    logic        busy;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
`ifdef REGBANK_ARB_LOCK_EN
    logic [3:0]  lock;
`endif

    logic [7:0]  mem [8];
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  exp_gnt;
        logic [2:0]  a;
        logic [7:0]  d;
    } vec_t;

    vec_t tbl [4];

    regbank_arbiter #(.NREQ(4), .DW(8), .AW(3)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`ifdef REGBANK_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank(input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            chk($sformatf("%s_bank%0d", tag, a), {24'h0, rd_data}, {24'h0, mem[a]});
        end
    endtask

    initial begin
        tbl[0] = '{4'b0001, {3'd1, 3'd2, 3'd5, 3'd3}, 32'h112233A5, 4'b0001, 3'd3, 8'hA5};
        tbl[1] = '{4'b0100, {3'd1, 3'd6, 3'd4, 3'd2}, 32'h445A6677, 4'b0100, 3'd6, 8'h5A};
        tbl[2] = '{4'b1000, {3'd7, 3'd0, 3'd1, 3'd2}, 32'hFF010203, 4'b1000, 3'd7, 8'hFF};
        tbl[3] = '{4'b0010, {3'd4, 3'd5, 3'd0, 3'd6}, 32'h09088107, 4'b0010, 3'd0, 8'h81};
        for (int a = 0; a < 8; a++) mem[a] = 8'h00;

        rstb    = 1'b1;
        req     = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
`ifdef REGBANK_ARB_LOCK_EN
        lock    = '0;
`endif
        #2 rstb = 1'b0;
        #1;
        chk("reset_gnt", {28'h0, gnt}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        check_bank("reset");

        // Single-requester writes; ptr ends at 2.
        for (int i = 0; i < 4; i++) begin
            req     = tbl[i].req;
            wr_addr = tbl[i].addr;
            wr_data = tbl[i].data;
            rd_addr = tbl[i].a;
            tick();
            chk($sformatf("vec%0d_gnt", i), {28'h0, gnt}, {28'h0, tbl[i].exp_gnt});
            chk($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h1);
            chk($sformatf("vec%0d_rd_old", i), {24'h0, rd_data}, {24'h0, mem[tbl[i].a]});
            req = '0;
            tick();
            chk($sformatf("vec%0d_gnt_off", i), {28'h0, gnt}, 32'h0);
            chk($sformatf("vec%0d_busy_off", i), {31'h0, busy}, 32'h0);
            mem[tbl[i].a] = tbl[i].d;
            chk($sformatf("vec%0d_rd_new", i), {24'h0, rd_data}, {24'h0, tbl[i].d});
        end

        // Requesters 1 and 3 with ptr=2: 3 wins, ptr wraps to 0, then 1.
        wr_addr = {3'd2, 3'd0, 3'd4, 3'd0};
        wr_data = {8'hC3, 8'h00, 8'h3D, 8'h00};
        req     = 4'b1010;
        tick();
        chk("rr13_first", {28'h0, gnt}, 32'h8);
        req = 4'b0010;
        tick();
        chk("rr13_gap", {28'h0, gnt}, 32'h0);
        mem[2] = 8'hC3;
        tick();
        chk("rr13_second", {28'h0, gnt}, 32'h2);
        req = '0;
        tick();
        mem[4] = 8'h3D;
        check_bank("rr13");

        // Reset while requester 2 is in GRANT.
        wr_addr = {3'd0, 3'd5, 3'd0, 3'd0};
        wr_data = {8'h00, 8'h3C, 8'h00, 8'h00};
        req     = 4'b0100;
        tick();
        chk("rstmid_gnt", {28'h0, gnt}, 32'h4);
        #2 rstb = 1'b0;
        #1;
        chk("rstmid_gnt_drop", {28'h0, gnt}, 32'h0);
        chk("rstmid_busy_drop", {31'h0, busy}, 32'h0);
        req = '0;
        @(posedge clk);
        #1 rstb = 1'b1;
        for (int a = 0; a < 8; a++) mem[a] = 8'h00;
        check_bank("rstmid");

        // All four requesting continuously: order 0,1,2,3,0 from ptr=0.
        wr_addr = {3'd6, 3'd5, 3'd2, 3'd1};
        wr_data = {8'h40, 8'h30, 8'h20, 8'h10};
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("all4_gnt%0d", k), {28'h0, gnt}, {28'h0, 4'b0001 << (k % 4)});
            chk($sformatf("all4_busy%0d", k), {31'h0, busy}, 32'h1);
            if (k == 4) req = '0;
            tick();
            chk($sformatf("all4_gap%0d", k), {28'h0, gnt}, 32'h0);
            mem[wr_addr[(k % 4)*3 +: 3]] = wr_data[(k % 4)*8 +: 8];
        end
        check_bank("all4");

`ifdef REGBANK_ARB_LOCK_EN
        // Requester 0 locks a 3-write burst while requester 1 waits.
        wr_addr = {3'd0, 3'd0, 3'd7, 3'd0};
        wr_data = {8'h00, 8'h00, 8'h77, 8'hE0};
        req     = 4'b0011;
        lock    = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("lock_gnt%0d", k), {28'h0, gnt}, 32'h1);
            if (k == 2) begin
                lock = '0;
                req  = 4'b0010;
            end
            tick();
            chk($sformatf("lock_gap%0d", k), {28'h0, gnt}, 32'h0);
            mem[k] = 8'hE0 + 8'(k);
            wr_addr[2:0] = 3'(k + 1);
            wr_data[7:0] = 8'hE0 + 8'(k + 1);
        end
        tick();
        chk("lock_then1", {28'h0, gnt}, 32'h2);
        req = '0;
        tick();
        mem[7] = 8'h77;
        check_bank("lock");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
